// File: rtl/bus_grant_controller.sv
// Bus grant controller: grants the bus to the client selected by the upstream
// arbiter, forwards that client's beats to the server, and closes the tenure
// on completion, abort or idle timeout with a one-cycle acknowledge.
module bus_grant_controller #(
  parameter int MAX_BEATS = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       client_1_rq,
  input  logic       client_2_rq,
  input  logic       client_3_rq,
  input  logic       client_4_rq,
  input  logic [1:0] address_to_be_served,
  input  logic       data_valid,
  input  logic       data_last,
  input  logic       server_ready,
  output logic [3:0] client_gnt,
  output logic       server_valid,
  output logic [1:0] server_addr,
  output logic       server_ack,
  output logic       timeout_err,
  output logic [7:0] beat_count
);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

  localparam logic [8:0] MAX_B = 9'(MAX_BEATS);
  localparam logic [8:0] TMO   = 9'(TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] rq;
  logic [1:0] idx;
  logic [7:0] idle_cnt;
  logic       to_q, to_set;
  logic       accept, fin, abrt, tmo;
  logic [8:0] beats_inc, idle_inc;

  assign rq        = {client_4_rq, client_3_rq, client_2_rq, client_1_rq};
  assign beats_inc = {1'b0, beat_count} + 9'd1;
  assign idle_inc  = {1'b0, idle_cnt} + 9'd1;

  // Tenure-close causes in XFER; a stalled beat is neither accepted nor idle.
  always_comb begin
    accept = (state == XFER) && data_valid && server_ready;
    fin    = accept && (data_last || (beats_inc == MAX_B));
    abrt   = !rq[idx];
    tmo    = !data_valid && (idle_inc >= TMO);
  end

  // Next-state and outputs; outputs depend only on registers and, for
  // server_valid, the same-cycle data_valid.
  always_comb begin
    state_nxt    = state;
    to_set       = 1'b0;
    client_gnt   = 4'b0000;
    server_valid = 1'b0;
    server_ack   = 1'b0;
    timeout_err  = 1'b0;
    server_addr  = idx;
    case (state)
      IDLE:  if (rq[address_to_be_served]) state_nxt = GRANT;
      GRANT: begin
        client_gnt = 4'b0001 << idx;
        state_nxt  = XFER;
      end
      XFER: begin
        client_gnt   = 4'b0001 << idx;
        server_valid = data_valid;
        if (fin || abrt || tmo) state_nxt = DONE;
        to_set = !fin && !abrt && tmo;
      end
      DONE: begin
        server_ack  = 1'b1;
        timeout_err = to_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched client index, beat and idle counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 2'b00;
      beat_count <= 8'd0;
      idle_cnt   <= 8'd0;
      to_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      to_q  <= to_set;
      case (state)
        IDLE: if (rq[address_to_be_served]) begin
          idx        <= address_to_be_served;
          beat_count <= 8'd0;
          idle_cnt   <= 8'd0;
        end
        GRANT: idle_cnt <= idle_inc[7:0];
        XFER: begin
          if (accept) begin
            beat_count <= beats_inc[7:0];
            idle_cnt   <= 8'd0;
          end else if (!data_valid) begin
            idle_cnt <= idle_inc[7:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_controller.sv
// Bench for bus_grant_controller: directed tenure scenarios followed by random
// traffic, every cycle compared against a tenure-level reference model.
module tb_bus_grant_controller;

  localparam int MAXB = 8;
  localparam int TMO  = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rq;
  logic [1:0] addr;
  logic       dv, last, rdy;
  logic [3:0] client_gnt;
  logic       server_valid, server_ack, timeout_err;
  logic [1:0] server_addr;
  logic [7:0] beat_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_grant_controller #(.MAX_BEATS(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .client_1_rq(rq[0]), .client_2_rq(rq[1]), .client_3_rq(rq[2]), .client_4_rq(rq[3]),
    .address_to_be_served(addr), .data_valid(dv), .data_last(last), .server_ready(rdy),
    .client_gnt(client_gnt), .server_valid(server_valid), .server_addr(server_addr),
    .server_ack(server_ack), .timeout_err(timeout_err), .beat_count(beat_count)
  );

  // Reference model: a tenure is "held" from the grant cycle until its
  // closing ack cycle; age 0 is the grant cycle, later cycles carry beats.
  bit m_held, m_ack, m_to;
  int m_age, m_idx, m_beats, m_idle;
  int acks = 0, tos = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_held = 0; m_ack = 0; m_to = 0;
    m_age = 0; m_idx = 0; m_beats = 0; m_idle = 0;
  endtask

  task automatic model_edge();
    bit acc, fin, ab, to;
    if (!reset) begin
      model_clear();
    end else if (m_ack) begin
      m_ack = 0; m_to = 0;
    end else if (m_held) begin
      if (m_age == 0) begin
        m_age = 1;
        m_idle++;
      end else begin
        acc = dv && rdy;
        fin = acc && (last || (m_beats + 1 == MAXB));
        ab  = !rq[m_idx];
        to  = 0;
        if (acc) begin
          m_beats++;
          m_idle = 0;
        end else if (!dv) begin
          m_idle++;
          to = (m_idle >= TMO);
        end
        if (fin || ab || to) begin
          m_held = 0;
          m_ack  = 1;
          m_to   = !fin && !ab && to;
        end
      end
    end else if (rq[addr]) begin
      m_held = 1; m_age = 0; m_idx = addr; m_beats = 0; m_idle = 0;
    end
  endtask

  // One cycle: compare outputs mid-cycle, then advance the model at the edge
  // with the inputs that were sampled, then let the caller drive new inputs.
  task automatic step();
    @(negedge clk);
    chk("client_gnt", client_gnt, m_held ? (1 << m_idx) : 0);
    chk("server_valid", server_valid, (m_held && m_age > 0) ? int'(dv) : 0);
    chk("server_addr", server_addr, m_idx);
    chk("server_ack", server_ack, int'(m_ack));
    chk("timeout_err", timeout_err, int'(m_ack && m_to));
    chk("beat_count", beat_count, m_beats);
    if (server_ack) acks++;
    if (timeout_err) tos++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit r, input logic [3:0] q, input logic [1:0] a,
                       input bit v, input bit l, input bit y);
    reset = r; rq = q; addr = a; dv = v; last = l; rdy = y;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int a0, t0;
    model_clear();
    drive(0, 4'b0000, 2'b00, 0, 0, 0);
    @(posedge clk);
    model_edge();
    #1;
    step();                                  // reset values
    drive(1, 4'b0000, 2'b00, 0, 0, 0);
    run(2);

    // Client 2, three beats, last on the third.
    a0 = acks;
    drive(1, 4'b0010, 2'b01, 0, 0, 1);
    step();                                  // match sampled here
    chk("gnt_latency", client_gnt, 4'b0010);
    drive(1, 4'b0010, 2'b01, 1, 0, 1);
    step();                                  // grant cycle
    run(2);
    drive(1, 4'b0010, 2'b01, 1, 1, 1);
    step();
    chk("s1_beats", beat_count, 3);
    drive(1, 4'b0000, 2'b01, 0, 0, 1);
    run(3);
    chk("s1_one_ack", acks - a0, 1);

    // Client 1 streams without last: closes at MAX_BEATS.
    drive(1, 4'b0001, 2'b00, 1, 0, 1);
    run(MAXB + 2);
    chk("s2_beats", beat_count, MAXB);
    drive(1, 4'b0000, 2'b00, 0, 0, 1);
    run(3);

    // Client 3 granted, never sends: timeout.
    t0 = tos;
    drive(1, 4'b0100, 2'b10, 0, 0, 1);
    run(TMO + 4);
    chk("s3_timeout", tos - t0, 1);
    drive(1, 4'b0000, 2'b10, 0, 0, 1);
    run(2);

    // Long stall with valid held: no timeout, then beats count.
    t0 = tos;
    drive(1, 4'b0001, 2'b00, 1, 0, 0);
    run(22);
    chk("s4_stall_beats", beat_count, 0);
    drive(1, 4'b0001, 2'b00, 1, 0, 1);
    run(3);
    chk("s4_no_timeout", tos - t0, 0);
    drive(1, 4'b0000, 2'b00, 0, 0, 1);
    run(8);

    // Client 4 abort after two beats, then abort coinciding with last.
    t0 = tos;
    drive(1, 4'b1000, 2'b11, 1, 0, 1);
    run(4);
    drive(1, 4'b0000, 2'b11, 1, 0, 1);
    run(3);
    drive(1, 4'b1000, 2'b11, 1, 0, 1);
    run(4);
    drive(1, 4'b0000, 2'b11, 1, 1, 1);
    run(3);
    chk("s5_no_timeout", tos - t0, 0);

    // Reset mid-tenure with five beats counted.
    a0 = acks;
    drive(1, 4'b0001, 2'b00, 1, 0, 1);
    run(7);
    chk("s6_beats", beat_count, 5);
    drive(0, 4'b0001, 2'b00, 1, 0, 1);
    run(2);
    drive(1, 4'b0000, 2'b00, 0, 0, 1);
    run(2);
    chk("s6_no_ack", acks - a0, 0);

    // Random traffic; requests mostly persist so tenures run a while.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] q;
      q = rq;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) q[b] = ~q[b];
      drive($urandom_range(0, 199) != 0, q, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
